// File: rtl/irq_ctrl.sv
// Eight-line priority interrupt controller: synchronised edge capture, MASK/PEND/ISR
// registers, nested priority delivery and a three-state request handshake to the CPU.
module irq_ctrl (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] irq_in,
  output logic       int_req,
  output logic [2:0] int_vector,
  input  logic       int_ack,
  input  logic       eoi,
  input  logic       reg_wr,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata
);

  // Handshake: int_req is held, with int_vector frozen, from the IDLE->REQ edge until
  // the edge that samples int_ack=1; int_ack outside REQ is ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACKD = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] sync1_q, sync2_q, hist_q, edge_q;
  logic [7:0] mask_q, mask_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] vec_q, vec_d;

  logic [7:0] allow, elig, isr_lo, vec_oh;
  logic [2:0] elig_idx;
  logic       seen;

  always_ff @(posedge clk) begin
    if (arst) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
      hist_q  <= 8'h00;
      edge_q  <= 8'h00;
      mask_q  <= 8'hFF;
      pend_q  <= 8'h00;
      isr_q   <= 8'h00;
      state_q <= IDLE;
      vec_q   <= 3'd0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      edge_q  <= sync2_q & ~hist_q;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      isr_q   <= isr_d;
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  // A line is eligible only if no ISR bit at its own index or above in priority is set.
  always_comb begin
    seen     = 1'b0;
    allow    = 8'h00;
    elig_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      seen     = seen | isr_q[i];
      allow[i] = ~seen;
    end
    elig = pend_q & ~mask_q & allow;
    for (int i = 7; i >= 0; i--) begin
      if (elig[i]) elig_idx = 3'(i);
    end
  end

  assign isr_lo = isr_q & (~isr_q + 8'd1);
  assign vec_oh = 8'd1 << vec_q;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    isr_d   = isr_q;
    if (reg_wr && reg_addr == 2'd0) mask_d = reg_wdata;
    if (reg_wr && reg_addr == 2'd1) pend_d = pend_d & ~reg_wdata;
    if (eoi) isr_d = isr_q & ~isr_lo;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = REQ;
          vec_d   = elig_idx;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d = ACKD;
          pend_d  = pend_d & ~vec_oh;
          isr_d   = isr_d | vec_oh;
        end
      end
      ACKD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // New edges are applied last so they win over W1C and ack clears.
    pend_d = pend_d | edge_q;
  end

  assign int_req    = (state_q == REQ);
  assign int_vector = int_req ? vec_q : 3'd0;

  always_comb begin
    case (reg_addr)
      2'd0:    reg_rdata = mask_q;
      2'd1:    reg_rdata = pend_q;
      2'd2:    reg_rdata = isr_q;
      default: reg_rdata = {3'b000, int_req, state_q, |isr_q, |pend_q};
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic compared
// every cycle against a behavioural model built from a sample-history delay line.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] irq_in;
  logic       int_req;
  logic [2:0] int_vector;
  logic       int_ack, eoi, reg_wr;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  int total = 0;
  int bad   = 0;

  irq_ctrl dut (
    .clk(clk), .arst(arst), .irq_in(irq_in), .int_req(int_req), .int_vector(int_vector),
    .int_ack(int_ack), .eoi(eoi), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_hist[j] holds the irq_in sample taken j+1 edges ago; a line edge reaches PEND
  // three edges after the first high sample. m_state: 0 idle, 1 requesting, 2 acked.
  logic [7:0] m_mask, m_pend, m_isr;
  logic [7:0] m_hist [4];
  int         m_state, m_vec;
  logic [3:0] exp_q[$];

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  task automatic model_step();
    logic [7:0] edges, n_pend, n_isr, n_mask, cand;
    int n_state, n_vec, k, v;
    if (arst) begin
      m_mask = 8'hFF; m_pend = 8'h00; m_isr = 8'h00; m_state = 0; m_vec = 0;
      for (int j = 0; j < 4; j++) m_hist[j] = 8'h00;
    end else begin
      edges = m_hist[2] & ~m_hist[3];
      for (int j = 3; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = irq_in;
      n_pend = m_pend; n_isr = m_isr; n_mask = m_mask; n_state = m_state; n_vec = m_vec;
      if (reg_wr && reg_addr == 2'd0) n_mask = reg_wdata;
      if (reg_wr && reg_addr == 2'd1) n_pend = n_pend & ~reg_wdata;
      if (eoi && m_isr != 8'h00) n_isr[lowest(m_isr)] = 1'b0;
      if (m_state == 0) begin
        k = lowest(m_isr);
        cand = m_pend & ~m_mask;
        v = lowest(cand);
        if (v < k) begin n_state = 1; n_vec = v; end
      end else if (m_state == 1) begin
        if (int_ack) begin
          n_pend[m_vec] = 1'b0;
          n_isr[m_vec]  = 1'b1;
          n_state = 2;
        end
      end else begin
        n_state = 0;
      end
      n_pend = n_pend | edges;
      m_pend = n_pend; m_isr = n_isr; m_mask = n_mask; m_state = n_state; m_vec = n_vec;
    end
    exp_q.push_back({(m_state == 1), (m_state == 1) ? 3'(m_vec) : 3'd0});
  endtask

  function automatic logic [7:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_mask;
      2'd1:    return m_pend;
      2'd2:    return m_isr;
      default: return {3'b000, (m_state == 1), 2'(m_state), (m_isr != 0), (m_pend != 0)};
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic [3:0] e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    e = exp_q.pop_front();
    chk("int_req", {31'd0, int_req}, {31'd0, e[3]});
    chk("int_vector", {29'd0, int_vector}, {29'd0, e[2:0]});
    chk("reg_rdata", {24'd0, reg_rdata}, {24'd0, model_rd(reg_addr)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    arst = 1'b1; tick(); arst = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d; tick(); reg_wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    reg_addr = a; #1;
    chk(tag, {24'd0, reg_rdata}, {24'd0, exp});
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    irq_in = v; tick(); irq_in = 8'h00;
  endtask

  task automatic ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 12 && !int_req; i++) tick();
    chk(tag, {31'd0, int_req}, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    arst = 1'b1; irq_in = 8'h00; int_ack = 1'b0; eoi = 1'b0;
    reg_wr = 1'b0; reg_addr = 2'd0; reg_wdata = 8'h00;
    for (int j = 0; j < 4; j++) m_hist[j] = 8'h00;
    @(negedge clk);

    // basic delivery of line 5 and its latency
    do_reset();
    rd("rst_mask", 2'd0, 8'hFF);
    rd("rst_pend", 2'd1, 8'h00);
    chk("rst_req", {31'd0, int_req}, 32'd0);
    wr(2'd0, 8'h00);
    pulse_irq(8'h20);            // edge N
    idle(2);                     // N+1, N+2
    rd("pend_n2", 2'd1, 8'h00);
    idle(1);                     // N+3
    rd("pend_n3", 2'd1, 8'h20);
    chk("req_n3", {31'd0, int_req}, 32'd0);
    idle(1);                     // N+4
    chk("req_n4", {31'd0, int_req}, 32'd1);
    chk("vec_n4", {29'd0, int_vector}, 32'd5);
    ack();
    chk("req_ackd", {31'd0, int_req}, 32'd0);
    rd("pend_ack", 2'd1, 8'h00);
    rd("isr_ack", 2'd2, 8'h20);
    rd("stat_ackd", 2'd3, 8'h0A);
    do_eoi();

    // simultaneous lines 2 and 6; nesting holds back the lower priority
    do_reset();
    wr(2'd0, 8'h00);
    pulse_irq(8'h44);
    wait_req("req_2");
    chk("vec_2", {29'd0, int_vector}, 32'd2);
    ack();
    chk("gap", {31'd0, int_req}, 32'd0);
    idle(6);
    chk("blocked_6", {31'd0, int_req}, 32'd0);
    do_eoi();
    wait_req("req_6");
    chk("vec_6", {29'd0, int_vector}, 32'd6);
    ack(); do_eoi();

    // line 4 in service, lines 1 and 7 arrive
    do_reset();
    wr(2'd0, 8'h00);
    pulse_irq(8'h10);
    wait_req("req_4"); ack();
    pulse_irq(8'h82);
    wait_req("req_1");
    chk("vec_1", {29'd0, int_vector}, 32'd1);
    ack();
    rd("isr_12", 2'd2, 8'h12);
    do_eoi();
    rd("isr_10", 2'd2, 8'h10);
    idle(6);
    chk("no_req_7", {31'd0, int_req}, 32'd0);
    rd("pend_80", 2'd1, 8'h80);

    // masking, unmask delivery, W1C versus new edge
    do_reset();
    pulse_irq(8'h08);
    idle(4);
    rd("pend_masked", 2'd1, 8'h08);
    chk("masked_req", {31'd0, int_req}, 32'd0);
    wr(2'd0, 8'hF7);
    chk("unmask_w", {31'd0, int_req}, 32'd0);
    idle(1);
    chk("unmask_req", {31'd0, int_req}, 32'd1);
    chk("unmask_vec", {29'd0, int_vector}, 32'd3);
    ack();
    rd("pend_clr3", 2'd1, 8'h00);
    pulse_irq(8'h08);            // edge N
    idle(2);                     // N+1, N+2
    wr(2'd1, 8'h08);             // W1C lands on N+3 with the edge
    rd("w1c_race", 2'd1, 8'h08);

    // frozen vector in REQ, then reset mid-request
    do_reset();
    wr(2'd0, 8'h00);
    pulse_irq(8'h40);
    wait_req("req_v6");
    pulse_irq(8'h01);
    idle(5);
    chk("frozen_vec", {29'd0, int_vector}, 32'd6);
    chk("frozen_req", {31'd0, int_req}, 32'd1);
    int_ack = 1'b1; eoi = 1'b1; reg_wr = 1'b1; reg_addr = 2'd0; reg_wdata = 8'h00;
    do_reset();
    int_ack = 1'b0; eoi = 1'b0; reg_wr = 1'b0;
    chk("rst_mid_req", {31'd0, int_req}, 32'd0);
    rd("rst_mid_mask", 2'd0, 8'hFF);
    rd("rst_mid_isr", 2'd2, 8'h00);

    // stray eoi and int_ack while idle
    idle(8);
    rd("stat_idle", 2'd3, 8'h00);
    do_eoi(); ack();
    rd("stat_stray", 2'd3, 8'h00);
    rd("isr_stray", 2'd2, 8'h00);

    // line held high across reset release is one edge
    wr(2'd0, 8'h00);
    irq_in = 8'h01;
    do_reset();
    wr(2'd0, 8'h00);
    wait_req("held_req");
    chk("held_vec", {29'd0, int_vector}, 32'd0);
    ack();
    idle(8);
    chk("held_once", {31'd0, int_req}, 32'd0);
    irq_in = 8'h00;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 9) == 0) irq_in[b] = ~irq_in[b];
      arst     = ($urandom_range(0, 149) == 0);
      int_ack  = int_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      eoi      = ($urandom_range(0, 11) == 0);
      reg_wr   = ($urandom_range(0, 9) == 0);
      reg_addr = 2'($urandom_range(0, 3));
      reg_wdata = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom) & 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
